demux_credit_sched: RTL and testbench
=====================================

DEMUX_CREDIT_SCHED -- requirements
Module: demux_credit_sched

Interface
REQ-001 The block SHALL expose parameters, one per line:
- NUM_DATA, 4, number of output lanes.
- DATA_BW, 8, width of one data word in bits.
- CREDITS, 4, credits per lane after reset; value 1..15.
- SEL_WIDTH is derived as `log2(NUM_DATA) and is not user-set.

REQ-002 The block SHALL expose ports, one per line:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream word present.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  DATA_BW  upstream word.
- in_dest  in  SEL_WIDTH  destination lane index.
- credit_ret  in  NUM_DATA  one-cycle pulse per lane; each pulse returns one credit.
- out_data  out  DATA_BW*NUM_DATA  lane i at bits [i*DATA_BW +: DATA_BW].
- out_valid  out  NUM_DATA  one-hot or zero; lane i word valid this cycle.
- busy  out  1  holding register occupied.
- err_credit  out  1  sticky credit-overflow flag.
- err_dest  out  1  sticky illegal-destination flag.

Function
REQ-003 The block SHALL contain one holding register (data, dest) and a 2-state FSM:
- EMPTY: no word held.
- HELD: a word is held.

REQ-004 A word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.

REQ-005 in_ready SHALL equal (state==EMPTY) OR fire, where fire = (state==HELD) AND (credit[dest]>0) AND (dest<NUM_DATA).
- in_ready is combinational; back-to-back words are therefore accepted at one word per cycle.

REQ-006 FSM transitions SHALL be:
- EMPTY→HELD on accept.
- HELD→HELD on fire with accept, or when fire=0 and dest is legal (stall).
- HELD→EMPTY on fire without accept, or on illegal dest.

REQ-007 On a fire edge, the block SHALL register out_valid[dest]=1 and out_data lane dest = held data.
- All other lanes SHALL be 0 (demux semantics).
- The outputs are valid for exactly the following cycle.

REQ-008 out_valid and out_data SHALL be 0 in any cycle not immediately following a fire edge.

REQ-009 Latency SHALL be fixed: a word accepted at edge N with credit available appears on out_valid in the cycle after edge N+1 (2 edges). Sustained throughput SHALL be 1 word per cycle while credits last.

REQ-010 Each lane SHALL have a credit counter of width `log2(CREDITS+1), initialised to CREDITS.

REQ-011 Credit counter update per lane per edge:
- fire to lane i only: decrement by 1.
- credit_ret[i] only: increment by 1.
- Both in the same cycle: unchanged.
- Neither: unchanged.

REQ-012 A credit_ret[i] pulse when counter i == CREDITS with no fire to lane i SHALL leave the counter at CREDITS and set err_credit.

REQ-013 A held word with in_dest ≥ NUM_DATA (possible only when NUM_DATA is not a power of two) SHALL be dropped in one cycle.
- It produces no output, consumes no credit, and sets err_dest.

REQ-014 err_credit and err_dest SHALL remain set until rst.

REQ-015 A stall, i.e. HELD with credit[dest]==0, SHALL hold data and dest stable and keep in_ready=0 until a credit returns to that lane.
- A credit_ret to the stalled lane SHALL allow fire on the next edge, not the same edge.

REQ-016 busy SHALL equal (state==HELD).

REQ-017 Multiple credit_ret bits asserted in one cycle SHALL each be processed independently.

Reset
REQ-018 While rst=1, asynchronously:
- state=EMPTY and the held word is discarded.
- All credit counters are set to CREDITS.
- out_valid=0, out_data=0, err_credit=0, err_dest=0, busy=0.
- in_ready=1.

REQ-019 Reset asserted mid-stall or mid-burst SHALL discard the held word with no output pulse; operation SHALL resume on the first edge after rst deasserts.

Verification
REQ-020 Reset, then one word 0xA5 to dest 2 → out_valid=4'b0100 and out_data=0x00A50000, two edges after accept; credit[2]=3.

REQ-021 Burst of 5 words to dest 1 at full rate, no credit_ret → 4 outputs on consecutive cycles, then stall with in_ready=0 and busy=1.
- A credit_ret[1] pulse then releases the 5th word; credit[1] ends at 0.

REQ-022 credit_ret[3] at credit[3]==4 with no traffic → credit[3] stays 4 and err_credit=1 until rst.

REQ-023 Simultaneous fire to lane 0 and credit_ret[0] at credit 2 → credit stays 2; output still emitted.

REQ-024 NUM_DATA=3, word to dest 3 → no out_valid, err_dest=1, next word to dest 0 delivered normally.

REQ-025 rst pulsed during the REQ-021 stall → outputs 0, credits all 4, in_ready=1, and no stale word is emitted after release.

Source files
------------

// File: rtl/demux_credit_sched.sv
// -----------------------------------------------------------------------------
// demux_credit_sched
//
// Single-entry credit-gated demultiplexer. Each accepted upstream word is
// parked in a one-word holding register. It is forwarded to its destination
// lane on the next edge where that lane has at least one credit. Each forward
// spends one credit on the lane. Downstream returns credits with single-cycle
// pulses on credit_ret.
//
// Only one lane is driven in any output cycle. All other lanes read zero.
//
// A word whose destination index is not a real lane is discarded after one
// held cycle. It produces no output, consumes no credit, and raises a sticky
// error flag. This can only happen when NUM_DATA is not a power of two.
//
// Parameters
//   NUM_DATA  : number of output lanes
//   DATA_BW   : width of one data word
//   CREDITS   : credits per lane after reset (1..15)
//   SEL_WIDTH : derived width of the destination index (not user-set)
//
// Ports
//   clk        : clock, rising-edge active
//   rst        : asynchronous active-high reset
//   in_valid   : upstream word present
//   in_ready   : word accepted this cycle (combinational)
//   in_data    : upstream word
//   in_dest    : destination lane index
//   credit_ret : per-lane credit return pulses
//   out_data   : lane i occupies bits [i*DATA_BW +: DATA_BW]
//   out_valid  : one-hot or zero; lane i word valid this cycle
//   busy       : holding register occupied
//   err_credit : sticky, a credit was returned to a full lane
//   err_dest   : sticky, a word with an illegal destination was dropped
// -----------------------------------------------------------------------------
module demux_credit_sched #(
    parameter  int NUM_DATA  = 4,
    parameter  int DATA_BW   = 8,
    parameter  int CREDITS   = 4,
    localparam int SEL_WIDTH = (NUM_DATA > 1) ? $clog2(NUM_DATA) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_BW-1:0]          in_data,
    input  logic [SEL_WIDTH-1:0]        in_dest,
    input  logic [NUM_DATA-1:0]         credit_ret,
    output logic [DATA_BW*NUM_DATA-1:0] out_data,
    output logic [NUM_DATA-1:0]         out_valid,
    output logic                        busy,
    output logic                        err_credit,
    output logic                        err_dest
);

    // Counter wide enough to hold the full credit allowance.
    localparam int CNT_W = $clog2(CREDITS + 1);

    localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(CREDITS);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [SEL_WIDTH:0] LANES_EXT = (SEL_WIDTH + 1)'(NUM_DATA);

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                        state_q,      state_d;
    logic [DATA_BW-1:0]            data_q,       data_d;
    logic [SEL_WIDTH-1:0]          dest_q,       dest_d;
    logic [CNT_W-1:0]              credit_q [NUM_DATA];
    logic [CNT_W-1:0]              credit_d [NUM_DATA];
    logic [NUM_DATA-1:0]           out_valid_q,  out_valid_d;
    logic [DATA_BW*NUM_DATA-1:0]   out_data_q,   out_data_d;
    logic                          err_credit_q, err_credit_d;
    logic                          err_dest_q,   err_dest_d;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    logic dest_legal;
    logic credit_avail;
    logic fire;
    logic drop;
    logic accept;

    // Zero-extend the index so that a lane count that is an exact power of
    // two still compares correctly.
    assign dest_legal = ({1'b0, dest_q} < LANES_EXT);

    // The lanes are scanned instead of indexing credit_q with dest_q. An
    // illegal index therefore never reads past the end of the array.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a
        // default value first. Otherwise a path that skips the assignment
        // infers a latch.
        credit_avail = 1'b0;
        for (int i = 0; i < NUM_DATA; i++) begin
            if (dest_q == SEL_WIDTH'(i) && credit_q[i] != '0) begin
                credit_avail = 1'b1;
            end
        end
    end

    assign fire     = (state_q == HELD) && dest_legal && credit_avail;
    assign drop     = (state_q == HELD) && !dest_legal;
    // A fire in the same cycle frees the holding register, so a new word can
    // enter behind it. This sustains one word per cycle.
    assign in_ready = (state_q == EMPTY) || fire;
    assign accept   = in_valid && in_ready;

    // -------------------------------------------------------------------------
    // Holding register and FSM next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dest_d  = dest_q;
        if (accept) begin
            state_d = HELD;
            data_d  = in_data;
            dest_d  = in_dest;
        end else if (fire || drop) begin
            state_d = EMPTY;
        end
        // A stall (HELD, legal dest, no credit) falls through and keeps the
        // data and dest values unchanged.
    end

    // -------------------------------------------------------------------------
    // Registered demux outputs: one lane carries the word, the rest read zero
    // -------------------------------------------------------------------------
    always_comb begin
        out_valid_d = '0;
        out_data_d  = '0;
        for (int i = 0; i < NUM_DATA; i++) begin
            if (fire && dest_q == SEL_WIDTH'(i)) begin
                out_valid_d[i]                    = 1'b1;
                out_data_d[i*DATA_BW +: DATA_BW]  = data_q;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-lane credit counters and the error flags
    // -------------------------------------------------------------------------
    always_comb begin
        err_credit_d = err_credit_q;
        err_dest_d   = err_dest_q | drop;
        for (int i = 0; i < NUM_DATA; i++) begin
            credit_d[i] = credit_q[i];
            // A spend and a return in the same cycle cancel each other.
            if (fire && dest_q == SEL_WIDTH'(i)) begin
                if (!credit_ret[i]) begin
                    credit_d[i] = credit_q[i] - CNT_ONE;
                end
            end else if (credit_ret[i]) begin
                // A return to a full lane is a downstream protocol error.
                // The counter saturates at its maximum.
                if (credit_q[i] == CNT_FULL) begin
                    err_credit_d = 1'b1;
                end else begin
                    credit_d[i] = credit_q[i] + CNT_ONE;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Flops
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments. All flops
        // therefore sample the pre-edge values, whatever order they are
        // written in.
        if (rst) begin
            state_q      <= EMPTY;
            // NOTE: the holding register is cleared on reset even though the
            // EMPTY state already marks it invalid. This keeps X out of
            // simulation and makes the discard of a held word explicit.
            data_q       <= '0;
            dest_q       <= '0;
            out_valid_q  <= '0;
            out_data_q   <= '0;
            err_credit_q <= 1'b0;
            err_dest_q   <= 1'b0;
            for (int i = 0; i < NUM_DATA; i++) begin
                credit_q[i] <= CNT_FULL;
            end
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            dest_q       <= dest_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            err_credit_q <= err_credit_d;
            err_dest_q   <= err_dest_d;
            for (int i = 0; i < NUM_DATA; i++) begin
                credit_q[i] <= credit_d[i];
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign busy       = (state_q == HELD);
    assign err_credit = err_credit_q;
    assign err_dest   = err_dest_q;

endmodule

// File: tb/tb_demux_credit_sched.sv
// -----------------------------------------------------------------------------
// tb_demux_credit_sched
//
// Self-checking bench for demux_credit_sched.
//
// The main instance uses the default parameters (4 lanes, 8-bit words,
// 4 credits). It is compared on every cycle against a transaction-level
// model: the model holds at most one pending word, a credit table and the
// expected output of the previous edge.
//
// A second instance with three lanes exercises the illegal-destination drop.
// -----------------------------------------------------------------------------
module tb_demux_credit_sched;

    localparam int N  = 4;
    localparam int BW = 8;
    localparam int CR = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance (4 lanes)
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [BW-1:0]   in_data = '0;
    logic [1:0]      in_dest = '0;
    logic [N-1:0]    credit_ret = '0;
    logic [N*BW-1:0] out_data;
    logic [N-1:0]    out_valid;
    logic            busy, err_credit, err_dest;

    // Second instance (3 lanes)
    logic            in_valid_3 = 1'b0;
    logic            in_ready_3;
    logic [BW-1:0]   in_data_3 = '0;
    logic [1:0]      in_dest_3 = '0;
    logic [2:0]      credit_ret_3 = '0;
    logic [3*BW-1:0] out_data_3;
    logic [2:0]      out_valid_3;
    logic            busy_3, err_credit_3, err_dest_3;

    demux_credit_sched #(.NUM_DATA(N), .DATA_BW(BW), .CREDITS(CR)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dest(in_dest),
        .credit_ret(credit_ret), .out_data(out_data), .out_valid(out_valid),
        .busy(busy), .err_credit(err_credit), .err_dest(err_dest)
    );

    demux_credit_sched #(.NUM_DATA(3), .DATA_BW(BW), .CREDITS(CR)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_3), .in_ready(in_ready_3), .in_data(in_data_3), .in_dest(in_dest_3),
        .credit_ret(credit_ret_3), .out_data(out_data_3), .out_valid(out_valid_3),
        .busy(busy_3), .err_credit(err_credit_3), .err_dest(err_dest_3)
    );

    int checks = 0;
    int errors = 0;
    int lane1_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model: a pending word, a credit table, last edge's output
    // -------------------------------------------------------------------------
    bit              m_held;
    int              m_data;
    int              m_dest;
    int              m_cred [N];
    bit              m_err_c, m_err_d;
    logic [N-1:0]    m_ov;
    logic [N*BW-1:0] m_od;

    task automatic model_reset();
        m_held  = 0;
        m_data  = 0;
        m_dest  = 0;
        m_err_c = 0;
        m_err_d = 0;
        m_ov    = '0;
        m_od    = '0;
        for (int i = 0; i < N; i++) m_cred[i] = CR;
    endtask

    function automatic bit model_can_send();
        return m_held && (m_dest < N) && (m_cred[m_dest] > 0);
    endfunction

    // Advance the model by one rising edge with the given inputs.
    task automatic model_edge(input bit v, input int d, input int dst, input logic [N-1:0] ret);
        bit send;
        bit ready;
        send  = model_can_send();
        ready = !m_held || send;
        m_ov  = '0;
        m_od  = '0;
        if (send) begin
            m_ov[m_dest]            = 1'b1;
            m_od[m_dest*BW +: BW]   = BW'(m_data);
        end
        if (m_held && m_dest >= N) m_err_d = 1;
        for (int i = 0; i < N; i++) begin
            bit spend;
            spend = send && (m_dest == i);
            if (spend && !ret[i]) begin
                m_cred[i] = m_cred[i] - 1;
            end else if (ret[i] && !spend) begin
                if (m_cred[i] == CR) m_err_c = 1;
                else                 m_cred[i] = m_cred[i] + 1;
            end
        end
        if (v && ready) begin
            m_held = 1;
            m_data = d;
            m_dest = dst;
        end else if (send || (m_held && m_dest >= N)) begin
            m_held = 0;
        end
    endtask

    // Compare every main-instance output with the model for this cycle.
    task automatic compare();
        check("in_ready",   in_ready,   !m_held || model_can_send());
        check("busy",       busy,       m_held);
        check("out_valid",  out_valid,  m_ov);
        check("out_data",   out_data,   m_od);
        check("err_credit", err_credit, m_err_c);
        check("err_dest",   err_dest,   m_err_d);
        for (int i = 0; i < N; i++) begin
            check($sformatf("credit[%0d]", i), u_dut.credit_q[i], m_cred[i]);
        end
    endtask

    // One cycle: drive at the falling edge, compare, then advance the model
    // over the coming rising edge.
    task automatic step_all(input bit v, input logic [BW-1:0] d, input int dst,
                            input logic [N-1:0] ret, input bit v3,
                            input logic [BW-1:0] d3, input logic [1:0] dst3);
        @(negedge clk);
        in_valid   = v;
        in_data    = d;
        in_dest    = 2'(dst);
        credit_ret = ret;
        in_valid_3 = v3;
        in_data_3  = d3;
        in_dest_3  = dst3;
        #1;
        compare();
        if (out_valid[1]) lane1_seen++;
        model_edge(v, int'(d), dst, ret);
    endtask

    task automatic step(input bit v, input logic [BW-1:0] d, input int dst, input logic [N-1:0] ret);
        step_all(v, d, dst, ret, 1'b0, '0, 2'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 0; credit_ret = '0; in_valid_3 = 0;
        rst = 1'b1;
        #1;
        check("rst out_valid",  out_valid,  0);
        check("rst out_data",   out_data,   0);
        check("rst in_ready",   in_ready,   1);
        check("rst busy",       busy,       0);
        check("rst err_credit", err_credit, 0);
        check("rst err_dest",   err_dest,   0);
        for (int i = 0; i < N; i++) check("rst credit", u_dut.credit_q[i], 4);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Single word 0xA5 to lane 2
        step(1, 8'hA5, 2, '0);
        step(0, '0, 0, '0);
        @(posedge clk); #1;
        check("single out_valid", out_valid, 4'b0100);
        check("single out_data",  out_data,  32'h00A5_0000);
        check("single credit2",   u_dut.credit_q[2], 3);

        // Burst of 5 to lane 1: four go out, then the fifth stalls
        lane1_seen = 0;
        for (int k = 0; k < 5; k++) step(1, 8'(8'h10 + k), 1, '0);
        for (int k = 0; k < 4; k++) step(0, '0, 0, '0);
        check("burst count", lane1_seen, 4);
        @(posedge clk); #1;
        check("stall in_ready", in_ready, 0);
        check("stall busy",     busy,     1);
        step(0, '0, 0, 4'b0010);
        step(0, '0, 0, '0);
        @(posedge clk); #1;
        check("release out_valid", out_valid, 4'b0010);
        check("release out_data",  out_data,  32'h0000_1400);
        check("release credit1",   u_dut.credit_q[1], 0);

        // Credit return to a full lane
        step(0, '0, 0, 4'b1000);
        @(posedge clk); #1;
        check("overflow err_credit", err_credit, 1);
        check("overflow credit3",    u_dut.credit_q[3], 4);
        for (int k = 0; k < 3; k++) step(0, '0, 0, '0);
        check("sticky err_credit", err_credit, 1);

        // Spend and return on lane 0 in the same cycle
        step(1, 8'h01, 0, '0);
        step(1, 8'h02, 0, '0);
        step(1, 8'h03, 0, '0);
        step(0, '0, 0, 4'b0001);
        @(posedge clk); #1;
        check("cancel credit0",   u_dut.credit_q[0], 2);
        check("cancel out_valid", out_valid, 4'b0001);
        check("cancel out_data",  out_data,  32'h0000_0003);

        // Reset in the middle of a stall: the held word must never emerge
        do_reset();
        for (int k = 0; k < 5; k++) step(1, 8'(8'h20 + k), 1, '0);
        for (int k = 0; k < 2; k++) step(0, '0, 0, '0);
        do_reset();
        lane1_seen = 0;
        for (int k = 0; k < 6; k++) step(0, '0, 0, '0);
        check("no stale word", lane1_seen, 0);

        // Randomized traffic, with one reset in the middle of the run
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] ret;
            for (int i = 0; i < N; i++) ret[i] = ($urandom_range(0, 7) == 0);
            if (c == 1500) do_reset();
            step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 3), ret);
        end

        // Three-lane instance: destination 3 is dropped, lane 0 still works
        step_all(0, '0, 0, '0, 1, 8'hEE, 2'd3);
        @(posedge clk); #1;
        check("bad dest busy",     busy_3,     1);
        check("bad dest in_ready", in_ready_3, 0);
        step_all(0, '0, 0, '0, 0, '0, 2'd0);
        @(posedge clk); #1;
        check("bad dest err_dest",  err_dest_3,  1);
        check("bad dest out_valid", out_valid_3, 0);
        check("bad dest busy2",     busy_3,      0);
        check("bad dest credits",   u_dut3.credit_q[0] + u_dut3.credit_q[1] + u_dut3.credit_q[2], 12);
        step_all(0, '0, 0, '0, 1, 8'h3C, 2'd0);
        step_all(0, '0, 0, '0, 0, '0, 2'd0);
        @(posedge clk); #1;
        check("after drop out_valid", out_valid_3, 3'b001);
        check("after drop out_data",  out_data_3,  24'h00_003C);
        check("after drop err_dest",  err_dest_3,  1);

        step(0, '0, 0, '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
